// File: rtl/bin_pkg.sv
// Shared defaults and types for the FFT bin counter.
package bin_pkg;

  localparam longint unsigned NUM_BINS_DEFAULT = 64'd4096;
  localparam int              CNT_W_DEFAULT    = 32;
  localparam int              FRAME_W_DEFAULT  = 32;

  typedef logic [CNT_W_DEFAULT-1:0] bin_idx_t;

endpackage

// File: rtl/bin_counter.sv
// Tags each accepted FFT output sample with its bin index and counts completed frames.
module bin_counter
  import bin_pkg::*;
#(
  parameter longint unsigned NUM_BINS = NUM_BINS_DEFAULT,
  parameter int              CNT_W    = CNT_W_DEFAULT,
  parameter int              FRAME_W  = FRAME_W_DEFAULT
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               fft_valid,
  output logic [CNT_W-1:0]   bin_num,
  output logic               bin_valid,
  output logic               first_bin,
  output logic               last_bin,
  output logic [FRAME_W-1:0] frame_cnt
);

  // Explicit compare rather than a mask so non-power-of-two frame sizes wrap correctly.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BINS - 64'd1);

  logic [CNT_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      idx       <= '0;
      bin_num   <= '0;
      bin_valid <= 1'b0;
      first_bin <= 1'b0;
      last_bin  <= 1'b0;
      frame_cnt <= '0;
    end else if (fft_valid) begin
      bin_num   <= idx;
      bin_valid <= 1'b1;
      first_bin <= (idx == '0);
      last_bin  <= (idx == LAST_IDX);
      if (idx == LAST_IDX) begin
        idx       <= '0;
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end else begin
        idx <= idx + CNT_W'(1);
      end
    end else begin
      bin_valid <= 1'b0;
      first_bin <= 1'b0;
      last_bin  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bin_counter.sv
// Randomized and directed bench for bin_counter, run on an 8-bin and a 4096-bin instance in parallel.
module tb_bin_counter;

  localparam longint unsigned NB_S = 64'd8;
  localparam longint unsigned NB_L = 64'd4096;

  logic        clk;
  logic        areset_n;
  logic        fft_valid;

  logic [31:0] bin_num_s, frame_cnt_s;
  logic        bin_valid_s, first_bin_s, last_bin_s;
  logic [31:0] bin_num_l, frame_cnt_l;
  logic        bin_valid_l, first_bin_l, last_bin_l;

  int checks = 0;
  int errors = 0;

  // Reference model: count of samples accepted since reset; bin and frame follow by division.
  longint unsigned n_acc     [2];
  longint unsigned exp_bin   [2];
  bit              exp_valid [2];
  bit              exp_first [2];
  bit              exp_last  [2];

  int last_pulses;

  bin_counter #(.NUM_BINS(NB_S), .CNT_W(32), .FRAME_W(32)) dut_s (
    .clk       (clk),
    .areset_n  (areset_n),
    .fft_valid (fft_valid),
    .bin_num   (bin_num_s),
    .bin_valid (bin_valid_s),
    .first_bin (first_bin_s),
    .last_bin  (last_bin_s),
    .frame_cnt (frame_cnt_s)
  );

  bin_counter #(.NUM_BINS(NB_L), .CNT_W(32), .FRAME_W(32)) dut_l (
    .clk       (clk),
    .areset_n  (areset_n),
    .fft_valid (fft_valid),
    .bin_num   (bin_num_l),
    .bin_valid (bin_valid_l),
    .first_bin (first_bin_l),
    .last_bin  (last_bin_l),
    .frame_cnt (frame_cnt_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint unsigned nb_of(input int k);
    return (k == 0) ? NB_S : NB_L;
  endfunction

  function automatic longint unsigned exp_frame(input int k);
    return (n_acc[k] / nb_of(k)) & 64'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("valid_s", 64'(bin_valid_s), 64'(exp_valid[0]));
    check("bin_s",   64'(bin_num_s),   exp_bin[0]);
    check("first_s", 64'(first_bin_s), 64'(exp_first[0]));
    check("last_s",  64'(last_bin_s),  64'(exp_last[0]));
    check("frame_s", 64'(frame_cnt_s), exp_frame(0));
    check("excl_s",  64'(first_bin_s & last_bin_s), 64'd0);
    check("valid_l", 64'(bin_valid_l), 64'(exp_valid[1]));
    check("bin_l",   64'(bin_num_l),   exp_bin[1]);
    check("first_l", 64'(first_bin_l), 64'(exp_first[1]));
    check("last_l",  64'(last_bin_l),  64'(exp_last[1]));
    check("frame_l", 64'(frame_cnt_l), exp_frame(1));
  endtask

  // Drive one clock's inputs, advance the model for that edge, then compare away from the edge.
  task automatic applyStimulus(input logic rst_n, input logic valid);
    areset_n  = rst_n;
    fft_valid = rst_n ? valid : 1'bx;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        n_acc[k]     = 0;
        exp_bin[k]   = 0;
        exp_valid[k] = 1'b0;
        exp_first[k] = 1'b0;
        exp_last[k]  = 1'b0;
      end else if (valid) begin
        exp_bin[k]   = n_acc[k] % nb_of(k);
        exp_valid[k] = 1'b1;
        exp_first[k] = (exp_bin[k] == 0);
        exp_last[k]  = (exp_bin[k] == nb_of(k) - 1);
        n_acc[k]++;
      end else begin
        exp_valid[k] = 1'b0;
        exp_first[k] = 1'b0;
        exp_last[k]  = 1'b0;
      end
    end
    #1;
    checkOutput();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      n_acc[k] = 0; exp_bin[k] = 0;
      exp_valid[k] = 1'b0; exp_first[k] = 1'b0; exp_last[k] = 1'b0;
    end

    // Reset then idle release
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    check("s31_bin", 64'(bin_num_s), 64'd0);

    // Single sample pulse
    applyStimulus(1'b1, 1'b1);
    check("s32_first", 64'(first_bin_s), 64'd1);
    check("s32_bin",   64'(bin_num_s),   64'd0);
    applyStimulus(1'b1, 1'b0);
    check("s32_hold",  64'(bin_num_s),   64'd0);
    check("s32_valid", 64'(bin_valid_s), 64'd0);

    // 17 continuous samples on 8 bins
    applyStimulus(1'b0, 1'b0);
    last_pulses = 0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b1);
      check("s33_seq", 64'(bin_num_s), 64'(i % 8));
      if (last_bin_s) last_pulses++;
    end
    check("s33_lastpulses", 64'(last_pulses), 64'd2);
    check("s33_frame",      64'(frame_cnt_s), 64'd2);

    // Alternating valid for 16 clocks
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, (i % 2) == 0);
      if ((i % 2) == 0) check("s34_seq", 64'(bin_num_s), 64'(i / 2));
    end
    check("s34_frame", 64'(frame_cnt_s), 64'd1);

    // Mid-frame reset with valid high discards the partial frame
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
    areset_n  = 1'b0;
    fft_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      n_acc[k] = 0; exp_bin[k] = 0;
      exp_valid[k] = 1'b0; exp_first[k] = 1'b0; exp_last[k] = 1'b0;
    end
    #1;
    checkOutput();
    applyStimulus(1'b1, 1'b1);
    check("s35_bin",   64'(bin_num_s),   64'd0);
    check("s35_first", 64'(first_bin_s), 64'd1);
    check("s35_frame", 64'(frame_cnt_s), 64'd0);

    // Full 4096-bin frame
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4096; i++) applyStimulus(1'b1, 1'b1);
    check("s36_bin",   64'(bin_num_l),   64'd4095);
    check("s36_last",  64'(last_bin_l),  64'd1);
    check("s36_frame", 64'(frame_cnt_l), 64'd1);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) >= 2), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_counter.md
BIN_COUNTER -- requirements
Module: bin_counter

Interface
REQ-001 Parameter NUM_BINS, default 4096, bins per FFT frame; legal range 2..2^32.
REQ-002 Parameter CNT_W, default 32, width of bin_num.
REQ-003 Parameter FRAME_W, default 32, width of frame_cnt.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 areset_n  input  1  reset, synchronous, active-low.
REQ-006 fft_valid  input  1  one FFT output sample is present this cycle.
REQ-007 bin_num  output  CNT_W  bin index of the most recently accepted sample.
REQ-008 bin_valid  output  1  bin_num/first_bin/last_bin refer to a sample accepted on the previous edge.
REQ-009 first_bin  output  1  reported sample is bin 0 of a frame.
REQ-010 last_bin  output  1  reported sample is bin NUM_BINS-1 of a frame.
REQ-011 frame_cnt  output  FRAME_W  number of completed frames, modulo 2^FRAME_W.

Function
REQ-012 An internal index register idx (0..NUM_BINS-1) SHALL hold the bin number the next accepted sample receives.
REQ-013 A sample SHALL be accepted on every rising edge where areset_n=1 and fft_valid=1; there is no back-pressure.
REQ-014 On acceptance, bin_num SHALL load idx, bin_valid SHALL go 1, and first_bin SHALL equal (idx==0), all one cycle after the accepting edge (latency 1).
REQ-015 On acceptance, last_bin SHALL equal (idx==NUM_BINS-1).
REQ-016 On acceptance, idx SHALL increment by 1, wrapping from NUM_BINS-1 to 0.
REQ-017 On acceptance with idx==NUM_BINS-1, frame_cnt SHALL increment by 1, wrapping at 2^FRAME_W.
REQ-018 On an edge with fft_valid=0, bin_valid, first_bin and last_bin SHALL be 0.
REQ-019 On an edge with fft_valid=0, bin_num, idx and frame_cnt SHALL hold their values.
REQ-020 Back-to-back valid cycles SHALL produce consecutive bin_num values with no gaps.
REQ-021 When fft_valid is 0 between samples, the gaps SHALL NOT advance idx.
REQ-022 first_bin and last_bin SHALL never be 1 on the same cycle, since NUM_BINS>=2.
REQ-023 All outputs SHALL be driven directly from registers.
REQ-024 fft_valid SHALL be ignored (X-tolerant) while areset_n=0.

Reset
REQ-025 On a rising edge with areset_n=0, the reset values SHALL be: idx=0, bin_num=0, bin_valid=0, first_bin=0, last_bin=0, frame_cnt=0.
REQ-026 Reset SHALL take priority over fft_valid on the same edge.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the first sample after release SHALL be bin 0.

Structure
REQ-028 A shared package bin_pkg SHALL hold the NUM_BINS default, the CNT_W and FRAME_W defaults, and a bin_idx_t typedef.
REQ-029 The design SHALL be a single module with no sub-modules.
REQ-030 The wrap logic SHALL be a compare against NUM_BINS-1, not a power-of-two mask, so that any NUM_BINS in range is supported.

Verification
REQ-031 Scenario: areset_n=0 for one edge, then release with fft_valid=0 -> all outputs 0.
REQ-032 Scenario: release reset, then fft_valid=1 for exactly one clock -> next cycle bin_valid=1, bin_num=0, first_bin=1, last_bin=0; the following cycle bin_valid=0 and bin_num stays 0.
REQ-033 Scenario: NUM_BINS=8, fft_valid held high for 17 clocks -> bin_num sequence 0..7,0..7,0; last_bin pulses at the two bin 7 samples; frame_cnt reads 2 at the end.
REQ-034 Scenario: NUM_BINS=8, fft_valid alternating 1/0 for 16 clocks -> bin_num 0..7 with bin_valid on alternate cycles; frame_cnt=1.
REQ-035 Scenario: NUM_BINS=8, 5 samples accepted, then areset_n=0 for one edge with fft_valid=1 -> outputs reset; the next accepted sample has bin_num=0 and first_bin=1; frame_cnt=0.
REQ-036 Scenario: NUM_BINS=4096, 4096 continuous samples -> the final sample has bin_num=4095 and last_bin=1; frame_cnt=1.
